// File: rtl/mux_pkg.sv
// Shared types and sizes for the 16:1 single-bit multiplexer.
package mux_pkg;

    localparam int N_IN  = 16;
    localparam int SEL_W = 4;

    typedef logic [N_IN-1:0]  mux_data_t;
    typedef logic [SEL_W-1:0] mux_sel_t;

endpackage : mux_pkg

// File: rtl/mux_4to1.sv
// 4:1 single-bit multiplexer leaf, used as both levels of the 16:1 tree.
module mux_4to1 (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);

    // Indexed select keeps an unknown sel visible as X on y in simulation.
    always_comb begin
        y = d[sel];
    end

endmodule : mux_4to1

// File: rtl/mux_16to1.sv
// 16:1 single-bit multiplexer with enable: combinational y plus a registered copy
// y_q and a valid flag that rises on the first clock edge after reset release.
module mux_16to1
    import mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   data_in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              en,
    output logic              y,
    output logic              y_q,
    output logic              y_vld
);

    mux_data_t data_s;
    mux_sel_t  sel_s;
    logic [3:0] lvl1_s;
    logic       tree_s;
    logic       y_s;
    logic       y_q_r;
    logic       y_vld_r;

    assign data_s = data_in;
    assign sel_s  = sel;

    // First level: each leaf picks one bit out of a nibble using sel[1:0].
    for (genvar g = 0; g < 4; g++) begin : g_lvl1
        mux_4to1 u_leaf (
            .d   (data_s[4*g +: 4]),
            .sel (sel_s[1:0]),
            .y   (lvl1_s[g])
        );
    end

    mux_4to1 u_root (
        .d   (lvl1_s),
        .sel (sel_s[3:2]),
        .y   (tree_s)
    );

    // Enable gating applied after the tree; this path never sees clk or rst_n.
    always_comb begin
        if (en) begin
            y_s = tree_s;
        end else begin
            y_s = 1'b0;
        end
    end

    assign y = y_s;

    // Output register with asynchronous clear; valid latches high after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q_r   <= 1'b0;
            y_vld_r <= 1'b0;
        end else begin
            y_q_r   <= y_s;
            y_vld_r <= 1'b1;
        end
    end

    assign y_q   = y_q_r;
    assign y_vld = y_vld_r;

endmodule : mux_16to1

// File: tb/tb_mux_16to1.sv
// Self-checking bench for mux_16to1: table vectors, walking-one sweep, random
// stimulus against a reference model, and reset sequences for the registered path.
module tb_mux_16to1;

    typedef struct {
        logic        en;
        logic [15:0] data;
        logic [3:0]  sel;
        logic        exp_y;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic [3:0]  sel;
    logic        en;
    logic        y;
    logic        y_q;
    logic        y_vld;

    int n_total;
    int n_pass;

    vec_t vecs[32];

    mux_16to1 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .sel     (sel),
        .en      (en),
        .y       (y),
        .y_q     (y_q),
        .y_vld   (y_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: shift the word right by the channel number and keep the LSB.
    function automatic logic model_y(input logic e, input logic [15:0] d, input int s);
        int v;
        v = int'(d);
        if (e == 1'b0) return 1'b0;
        return logic'((v / (1 << s)) % 2);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b (en=%b sel=%0d data=%h)",
                     name, act, exp, en, sel, data_in);
        end
    endtask

    initial begin
        int s_int;
        logic e_prev;
        logic [15:0] d_prev;
        int s_prev;
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b1;
        en      = 1'b0;
        sel     = 4'd0;
        data_in = 16'h0000;

        // Test 5 (first half): reset asserted with clock running.
        #2 rst_n = 1'b0;
        #1;
        check("rst_y_q", y_q, 1'b0);
        check("rst_y_vld", y_vld, 1'b0);
        en = 1'b1; sel = 4'd7; data_in = 16'h0080;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_y_q", y_q, 1'b0);
        check("rst_hold_y_vld", y_vld, 1'b0);
        check("y_during_reset", y, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("vld_before_edge", y_vld, 1'b0);
        @(posedge clk);
        #1;
        check("first_edge_y_q", y_q, 1'b1);
        check("first_edge_y_vld", y_vld, 1'b1);

        // Tests 1 and 2 as a vector table.
        for (int i = 0; i < 16; i++) begin
            vecs[i]      = '{1'b0, 16'hFFFF, 4'(i), 1'b0};
            vecs[16 + i] = '{1'b1, 16'hA5C3, 4'(i), model_y(1'b1, 16'hA5C3, i)};
        end
        vecs[16].exp_y = 1'b1;
        vecs[18].exp_y = 1'b0;
        vecs[31].exp_y = 1'b1;
        for (int i = 0; i < 32; i++) begin
            en = vecs[i].en; data_in = vecs[i].data; sel = vecs[i].sel;
            #1;
            check(i < 16 ? "en0_all_ones" : "pattern_A5C3", y, vecs[i].exp_y);
        end

        // Test 3: walking one against every select code.
        en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < 16; s++) begin
                data_in = 16'h0001 << k;
                sel = 4'(s);
                #1;
                check("walking_one", y, (s == k) ? 1'b1 : 1'b0);
            end
        end

        // Width rule: -1 truncates to en=1, sel=15.
        s_int = -1;
        en = s_int[0]; sel = s_int[3:0]; data_in = 16'h8000;
        #1;
        check("neg_one_trunc", y, 1'b1);

        // Test 4: random stimulus, combinational and registered path together.
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            en = 1'($urandom_range(0, 1));
            data_in = 16'($urandom);
            s_int = $urandom_range(0, 15);
            sel = 4'(s_int);
            #1;
            check("random_y", y, model_y(en, data_in, s_int));
            e_prev = en; d_prev = data_in; s_prev = s_int;
            @(posedge clk);
            #1;
            check("random_y_q", y_q, model_y(e_prev, d_prev, s_prev));
            check("random_y_vld", y_vld, 1'b1);
            @(negedge clk);
        end

        // Test 6: reset mid-stream while y is high.
        en = 1'b1; sel = 4'd3; data_in = 16'h0008;
        @(posedge clk);
        #1;
        check("pre_reset_y_q", y_q, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_y_q", y_q, 1'b0);
        check("mid_reset_y_vld", y_vld, 1'b0);
        check("mid_reset_y", y, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("recover_y_q", y_q, 1'b1);
        check("recover_y_vld", y_vld, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mux_16to1
